// File: rtl/alu_arbiter.sv
// Round-robin arbiter time-sharing one combinational ALU between N_REQ requesters.
// Operands and results are registered; each operation takes the path IDLE -> EXEC -> DONE.
module alu_arbiter #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 32,
    parameter int CTL_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    input  logic [N_REQ*CTL_W-1:0]  req_ctl,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_zero,
    output logic                    rsp_overflow,
    output logic [DATA_W-1:0]       alu_da,
    output logic [DATA_W-1:0]       alu_db,
    output logic [CTL_W-1:0]        alu_ctl,
    input  logic [DATA_W-1:0]       alu_dc,
    input  logic                    alu_zero,
    input  logic                    alu_overflow,
    output logic                    busy
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t            state;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     owner;
    logic [IW-1:0]     grant;
    logic              found;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [CTL_W-1:0]  op_ctl;
    logic [DATA_W-1:0] res;
    logic              res_zero;
    logic              res_ovf;

    // Scan starting at rr_ptr so the last-served requester goes to the back.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
                found = 1'b1;
                grant = IW'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && found) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state == DONE) begin
            rsp_valid[owner] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_ctl   <= '0;
            res      <= '0;
            res_zero <= 1'b0;
            res_ovf  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        op_a   <= req_a[grant*DATA_W +: DATA_W];
                        op_b   <= req_b[grant*DATA_W +: DATA_W];
                        op_ctl <= req_ctl[grant*CTL_W +: CTL_W];
                        owner  <= grant;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    res      <= alu_dc;
                    res_zero <= alu_zero;
                    res_ovf  <= alu_overflow;
                    state    <= DONE;
                end
                DONE: begin
                    if (rsp_ready[owner]) begin
                        rr_ptr <= (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign alu_da       = op_a;
    assign alu_db       = op_b;
    assign alu_ctl      = op_ctl;
    assign rsp_data     = res;
    assign rsp_zero     = res_zero;
    assign rsp_overflow = res_ovf;
    assign busy         = (state != IDLE);

endmodule
